router_output_allocator: RTL and testbench
==========================================

// Module: router_output_allocator
// PURPOSE
//  Packet-granular output-port allocator for the mesh router. Each input channel
//  (FIFO head) presents the output port its current packet needs. Per output, a
//  round-robin arbiter grants one input and holds that grant until the packet's
//  TLAST beat transfers. Grants drive the router crossbar mux selects; a per-output
//  beat watchdog breaks runaway packets that never deliver TLAST.
// PARAMETERS
//  IN_CHANNELS      5                         input channels (N,E,S,W,local)
//  OUT_CHANNELS     5                         output ports
//  IN_WIDTH         $clog2(IN_CHANNELS)       width of an input index
//  OUT_WIDTH        $clog2(OUT_CHANNELS)      width of a port index
//  MAX_BEATS        256                       watchdog limit, beats per packet (>=2)
//  BEAT_CNT_WIDTH   $clog2(MAX_BEATS+1)       beat counter width
// PORTS
//  clk_i          in   1                   clock
//  rst_i          in   1                   synchronous reset, active-high
//  req_valid_i    in   IN_CHANNELS         input i has a packet head waiting
//  req_port_i     in   IN_CHANNELS*OUT_WIDTH  requested output, slice [i*OUT_WIDTH +: OUT_WIDTH]
//  out_fire_i     in   OUT_CHANNELS        output o: TVALID && TREADY this cycle
//  out_last_i     in   OUT_CHANNELS        output o: TLAST of the firing beat
//  grant_valid_o  out  OUT_CHANNELS        output o is locked to an input
//  grant_idx_o    out  OUT_CHANNELS*IN_WIDTH  granted input index per output
//  in_granted_o   out  IN_CHANNELS         input i currently owns some output
//  wdog_err_o     out  OUT_CHANNELS        sticky: watchdog fired on output o
// BEHAVIOUR
//  - Reset: all outputs IDLE, grant_valid_o=0, grant_idx_o=0, in_granted_o=0,
//    wdog_err_o=0, rr_ptr[o]=0, beat_cnt[o]=0. A reset mid-packet drops every lock.
//  - Per-output FSM with states IDLE and BUSY. All outputs are registered.
//  - IDLE(o): the candidates for o are the inputs i where req_valid_i[i] is set,
//    req_port_i[i]==o, and in_granted_o[i]==0.
//  - IDLE(o), candidates present: pick the first candidate at or after rr_ptr[o],
//    searching circularly. On the next clock: state BUSY, grant_valid_o[o]=1,
//    grant_idx_o[o]=i, rr_ptr[o]=(i+1) mod IN_CHANNELS, beat_cnt[o]=0.
//    Grant latency is 1 cycle from the request.
//  - BUSY(o): the lock is held regardless of req_* changes. Every out_fire_i[o]
//    increments beat_cnt[o].
//  - BUSY(o), out_fire_i[o] && out_last_i[o]: go to IDLE on the next clock and
//    drop grant_valid_o[o]. The output holds at least 1 idle cycle between packets.
//  - BUSY(o), a non-last fire that makes beat_cnt reach MAX_BEATS: set wdog_err_o[o]
//    (sticky until reset) and force IDLE. Later beats of that packet re-arbitrate
//    normally.
//  - out_fire_i in IDLE is ignored. req_port_i >= OUT_CHANNELS is ignored; that
//    input never receives a grant.
//  - One input never holds two outputs: it requests one port, and busy inputs are
//    excluded from candidates.
//  - Outputs arbitrate independently and in parallel. Simultaneous grants on
//    different outputs in the same cycle are legal.
//  - grant_idx_o[o] is held at its last value while IDLE; consumers gate on
//    grant_valid_o.
//  - in_granted_o[i] = OR over o of (grant_valid_o[o] && grant_idx_o[o]==i).
//  - A release and a new request for the same input in the same cycle: the input
//    becomes eligible again once the output is IDLE.
// TESTING
//  1. Reset with all req=0 -> every output 0. req_valid[2]=1 with port 3 -> next
//     cycle grant_valid[3]=1, grant_idx[3]=2, in_granted[2]=1.
//  2. Inputs 0, 1 and 4 all request port 1 for 1-beat packets, held continuously
//     -> grants in order 0, 1, 4, 0, with one idle cycle between each.
//  3. Input 3 granted, 4-beat packet with TLAST on beat 4 and fire stalls in
//     between -> the grant holds through the stalls and drops 1 cycle after the
//     beat-4 fire.
//  4. Input 0 requests port 0 while input 1 requests port 2 in the same cycle ->
//     both grants assert on the same clock.
//  5. MAX_BEATS=4, 5-beat packet with no TLAST -> on the 4th fire wdog_err[o]=1 and
//     the lock is released; the error persists until rst_i.
//  6. rst_i asserted mid-packet -> next cycle all grants=0 and rr_ptr=0. A request
//     for port 4 from input 3 is regranted 1 cycle after rst_i deasserts.

Source files
------------

// File: rtl/router_output_allocator.sv
// Packet-granular output-port allocator: per-output round-robin arbitration with
// grant lock held until TLAST, plus a sticky per-output beat watchdog.
module router_output_allocator #(
  parameter int unsigned IN_CHANNELS    = 5,
  parameter int unsigned OUT_CHANNELS   = 5,
  parameter int unsigned IN_WIDTH       = $clog2(IN_CHANNELS),
  parameter int unsigned OUT_WIDTH      = $clog2(OUT_CHANNELS),
  parameter int unsigned MAX_BEATS      = 256,
  parameter int unsigned BEAT_CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [IN_CHANNELS-1:0]           req_valid_i,
  input  logic [IN_CHANNELS*OUT_WIDTH-1:0] req_port_i,
  input  logic [OUT_CHANNELS-1:0]          out_fire_i,
  input  logic [OUT_CHANNELS-1:0]          out_last_i,
  output logic [OUT_CHANNELS-1:0]          grant_valid_o,
  output logic [OUT_CHANNELS*IN_WIDTH-1:0] grant_idx_o,
  output logic [IN_CHANNELS-1:0]           in_granted_o,
  output logic [OUT_CHANNELS-1:0]          wdog_err_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state_q [OUT_CHANNELS];
  state_t                    state_d [OUT_CHANNELS];
  logic [IN_WIDTH-1:0]       idx_q   [OUT_CHANNELS];
  logic [IN_WIDTH-1:0]       idx_d   [OUT_CHANNELS];
  logic [IN_WIDTH-1:0]       rr_q    [OUT_CHANNELS];
  logic [IN_WIDTH-1:0]       rr_d    [OUT_CHANNELS];
  logic [BEAT_CNT_WIDTH-1:0] cnt_q   [OUT_CHANNELS];
  logic [BEAT_CNT_WIDTH-1:0] cnt_d   [OUT_CHANNELS];
  logic [OUT_CHANNELS-1:0]   err_q;
  logic [OUT_CHANNELS-1:0]   err_d;

  logic [IN_CHANNELS-1:0]    busy_in;
  logic [IN_CHANNELS-1:0]    cand    [OUT_CHANNELS];
  logic [OUT_CHANNELS-1:0]   found;
  logic [IN_WIDTH-1:0]       pick    [OUT_CHANNELS];

  always_comb begin
    busy_in = '0;
    for (int unsigned o = 0; o < OUT_CHANNELS; o++) begin
      for (int unsigned i = 0; i < IN_CHANNELS; i++) begin
        if (state_q[o] == BUSY && idx_q[o] == IN_WIDTH'(i)) busy_in[i] = 1'b1;
      end
    end
  end

  // Circular search from rr_ptr: first pass takes candidates at/after the pointer,
  // second pass wraps around to the lowest candidate.
  always_comb begin
    found = '0;
    for (int unsigned o = 0; o < OUT_CHANNELS; o++) begin
      cand[o] = '0;
      pick[o] = '0;
      for (int unsigned i = 0; i < IN_CHANNELS; i++) begin
        cand[o][i] = req_valid_i[i] && !busy_in[i] &&
                     (req_port_i[i*OUT_WIDTH +: OUT_WIDTH] == OUT_WIDTH'(o));
      end
      for (int unsigned i = 0; i < IN_CHANNELS; i++) begin
        if (!found[o] && cand[o][i] && IN_WIDTH'(i) >= rr_q[o]) begin
          found[o] = 1'b1;
          pick[o]  = IN_WIDTH'(i);
        end
      end
      for (int unsigned i = 0; i < IN_CHANNELS; i++) begin
        if (!found[o] && cand[o][i]) begin
          found[o] = 1'b1;
          pick[o]  = IN_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    for (int unsigned o = 0; o < OUT_CHANNELS; o++) begin
      state_d[o] = state_q[o];
      idx_d[o]   = idx_q[o];
      rr_d[o]    = rr_q[o];
      cnt_d[o]   = cnt_q[o];
      case (state_q[o])
        IDLE: begin
          if (found[o]) begin
            state_d[o] = BUSY;
            idx_d[o]   = pick[o];
            rr_d[o]    = (pick[o] == IN_WIDTH'(IN_CHANNELS - 1)) ? '0 : pick[o] + IN_WIDTH'(1);
            cnt_d[o]   = '0;
          end
        end
        BUSY: begin
          if (out_fire_i[o]) begin
            cnt_d[o] = cnt_q[o] + BEAT_CNT_WIDTH'(1);
            if (out_last_i[o]) begin
              state_d[o] = IDLE;
            end else if (cnt_q[o] + BEAT_CNT_WIDTH'(1) == BEAT_CNT_WIDTH'(MAX_BEATS)) begin
              state_d[o] = IDLE;
              err_d[o]   = 1'b1;
            end
          end
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned o = 0; o < OUT_CHANNELS; o++) begin
        state_q[o] <= IDLE;
        idx_q[o]   <= '0;
        rr_q[o]    <= '0;
        cnt_q[o]   <= '0;
      end
      err_q <= '0;
    end else begin
      for (int unsigned o = 0; o < OUT_CHANNELS; o++) begin
        state_q[o] <= state_d[o];
        idx_q[o]   <= idx_d[o];
        rr_q[o]    <= rr_d[o];
        cnt_q[o]   <= cnt_d[o];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    grant_idx_o = '0;
    for (int unsigned o = 0; o < OUT_CHANNELS; o++) begin
      grant_valid_o[o]                  = (state_q[o] == BUSY);
      grant_idx_o[o*IN_WIDTH +: IN_WIDTH] = idx_q[o];
    end
    in_granted_o = busy_in;
    wdog_err_o   = err_q;
  end

endmodule

// File: tb/tb_router_output_allocator.sv
// Directed bench for router_output_allocator with an owner-per-output reference
// model compared every cycle, plus literal expectations per scenario.
module tb_router_output_allocator;

  localparam int IC = 5;
  localparam int OC = 5;
  localparam int IW = 3;
  localparam int OW = 3;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [IC-1:0]    req_valid;
  logic [IC*OW-1:0] req_port;
  logic [OC-1:0]    out_fire;
  logic [OC-1:0]    out_last;
  logic [OC-1:0]    grant_valid;
  logic [OC*IW-1:0] grant_idx;
  logic [IC-1:0]    in_granted;
  logic [OC-1:0]    wdog_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  router_output_allocator #(
    .IN_CHANNELS (IC),
    .OUT_CHANNELS(OC),
    .MAX_BEATS   (MB)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_port_i   (req_port),
    .out_fire_i   (out_fire),
    .out_last_i   (out_last),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx),
    .in_granted_o (in_granted),
    .wdog_err_o   (wdog_err)
  );

  always #5 clk = ~clk;

  // Reference: owner[o] is the input holding output o, or -1 when free.
  int owner    [OC];
  int last_idx [OC];
  int ptr      [OC];
  int beats    [OC];
  bit m_err    [OC];
  bit busy_in  [IC];
  int pk;
  int c;

  always @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < OC; o++) begin
        owner[o] = -1; last_idx[o] = 0; ptr[o] = 0; beats[o] = 0; m_err[o] = 1'b0;
      end
    end else begin
      for (int i = 0; i < IC; i++) busy_in[i] = 1'b0;
      for (int o = 0; o < OC; o++) if (owner[o] >= 0) busy_in[owner[o]] = 1'b1;
      for (int o = 0; o < OC; o++) begin
        if (owner[o] >= 0) begin
          if (out_fire[o]) begin
            beats[o]++;
            if (out_last[o]) owner[o] = -1;
            else if (beats[o] == MB) begin
              m_err[o] = 1'b1;
              owner[o] = -1;
            end
          end
        end else begin
          pk = -1;
          for (int k = 0; k < IC; k++) begin
            c = (ptr[o] + k) % IC;
            if (pk < 0 && req_valid[c] && int'(req_port[c*OW +: OW]) == o && !busy_in[c]) pk = c;
          end
          if (pk >= 0) begin
            owner[o] = pk; last_idx[o] = pk; ptr[o] = (pk + 1) % IC; beats[o] = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [OC-1:0]    e_gv;
  logic [OC*IW-1:0] e_gi;
  logic [IC-1:0]    e_ig;
  logic [OC-1:0]    e_we;

  always @(negedge clk) begin
    if (chk_en) begin
      e_gv = '0; e_gi = '0; e_ig = '0; e_we = '0;
      for (int o = 0; o < OC; o++) begin
        if (owner[o] >= 0) begin
          e_gv[o] = 1'b1;
          e_ig[owner[o]] = 1'b1;
        end
        e_gi[o*IW +: IW] = IW'(last_idx[o]);
        e_we[o] = m_err[o];
      end
      chk("model_grant_valid", 32'(grant_valid), 32'(e_gv));
      chk("model_grant_idx", 32'(grant_idx), 32'(e_gi));
      chk("model_in_granted", 32'(in_granted), 32'(e_ig));
      chk("model_wdog_err", 32'(wdog_err), 32'(e_we));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int p);
    req_valid[i] = 1'b1;
    req_port[i*OW +: OW] = OW'(p);
  endtask

  function automatic logic [IW-1:0] gidx(input int o);
    logic [OC*IW-1:0] g;
    g = grant_idx;
    return g[o*IW +: IW];
  endfunction

  int exp_order [4] = '{0, 1, 4, 0};
  bit fire_pat  [7] = '{1, 0, 0, 1, 0, 1, 1};
  int nfire;

  initial begin
    rst = 1'b1; req_valid = '0; req_port = '0; out_fire = '0; out_last = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("reset_gv", 32'(grant_valid), 0);
    chk("reset_gi", 32'(grant_idx), 0);
    chk("reset_ig", 32'(in_granted), 0);
    chk("reset_we", 32'(wdog_err), 0);

    // Single request, one-cycle grant latency
    set_req(2, 3);
    cyc();
    chk("t1_gv3", 32'(grant_valid[3]), 1);
    chk("t1_gi3", 32'(gidx(3)), 2);
    chk("t1_ig2", 32'(in_granted), 32'h4);
    req_valid = '0;
    out_fire[3] = 1'b1; out_last[3] = 1'b1;
    cyc();
    out_fire = '0; out_last = '0;
    chk("t1_release", 32'(grant_valid), 0);
    chk("t1_idx_held", 32'(gidx(3)), 2);

    // Round-robin among inputs 0,1,4 on port 1
    set_req(0, 1); set_req(1, 1); set_req(4, 1);
    for (int n = 0; n < 4; n++) begin
      cyc();
      chk("t2_gv", 32'(grant_valid[1]), 1);
      chk("t2_order", 32'(gidx(1)), 32'(exp_order[n]));
      out_fire[1] = 1'b1; out_last[1] = 1'b1;
      cyc();
      out_fire = '0; out_last = '0;
      chk("t2_idle_gap", 32'(grant_valid[1]), 0);
      if (n == 3) req_valid = '0;
    end

    // Stalled 4-beat packet holds the lock
    set_req(3, 2);
    cyc();
    req_valid = '0;
    chk("t3_grant", 32'(gidx(2)), 3);
    nfire = 0;
    for (int n = 0; n < 7; n++) begin
      out_fire[2] = fire_pat[n];
      out_last[2] = fire_pat[n] && (nfire == 3);
      if (fire_pat[n]) nfire++;
      cyc();
      chk("t3_hold", 32'(grant_valid[2]), 32'(nfire < 4));
    end
    out_fire = '0; out_last = '0;

    // Parallel grants on two outputs
    set_req(0, 0); set_req(1, 2);
    cyc();
    req_valid = '0;
    chk("t4_both", 32'(grant_valid), 32'h5);
    chk("t4_idx0", 32'(gidx(0)), 0);
    chk("t4_idx2", 32'(gidx(2)), 1);
    out_fire = 5'b00101; out_last = 5'b00101;
    cyc();
    out_fire = '0; out_last = '0;

    // Watchdog: 5 beats, no TLAST, limit 4
    set_req(4, 4);
    cyc();
    req_valid = '0;
    chk("t5_grant", 32'(gidx(4)), 4);
    out_fire[4] = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      cyc();
      chk("t5_gv", 32'(grant_valid[4]), 32'(n < 4));
      chk("t5_err", 32'(wdog_err), (n >= 4) ? 32'h10 : 32'h0);
    end
    out_fire = '0;

    // Reset mid-packet, then regrant
    set_req(3, 4);
    cyc();
    chk("t6_grant", 32'(gidx(4)), 3);
    out_fire[4] = 1'b1;
    cyc();
    out_fire = '0;
    chk("t6_err_sticky", 32'(wdog_err), 32'h10);
    rst = 1'b1;
    cyc();
    chk("t6_rst_gv", 32'(grant_valid), 0);
    chk("t6_rst_ig", 32'(in_granted), 0);
    chk("t6_rst_we", 32'(wdog_err), 0);
    rst = 1'b0;
    cyc();
    chk("t6_regrant_gv", 32'(grant_valid), 32'h10);
    chk("t6_regrant_idx", 32'(gidx(4)), 3);
    out_fire[4] = 1'b1; out_last[4] = 1'b1;
    cyc();
    out_fire = '0; out_last = '0;
    req_valid = '0;

    // Out-of-range port never granted
    set_req(0, 7);
    cyc();
    cyc();
    chk("t7_bad_port", 32'(grant_valid), 0);
    req_valid = '0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
